vga_line_feeder: RTL and testbench
==================================

# vga_line_feeder

Double-buffered line source for the `vga` timing block. On each line-start pulse from `vga` it swaps display banks and fetches the next row, pixel by pixel, from an upstream pixel producer (renderer or SPI frame store) over a valid/ready stream. The displayed bank drives `vga.color_in` as a packed `Color` array while the other bank fills.

## Interface
Parameters:
- `LINE_PIXELS`, 480: pixels per line; width of each bank.
- `V_LINES`, 480: active rows; row-index wrap point.

Ports:
- `CLK25MHZ`  in  1  pixel clock; the block's only clock.
- `ck_rst`  in  1  reset, asynchronous, active-low.
- `next_line`  in  1  line-start level from `vga`, high for the hsync-pulse cycles; only its rising edge is used.
- `next_y`  in  10  current active row from `vga`; 0 outside active video.
- `req_valid`  out  1  row request to the producer.
- `req_y`  out  10  requested row, 0..V_LINES-1.
- `req_ready`  in  1  producer accepts the request.
- `pix_valid`  in  1  pixel beat valid.
- `pix_data`  in  12  pixel, RRRRGGGGBBBB.
- `pix_ready`  out  1  block accepts a pixel beat.
- `color_out`  out  LINE_PIXELS×12  displayed bank, packed `Color`; element i is pixel x=i.
- `line_ready`  out  1  fill bank complete; waiting for a swap.
- `underrun`  out  1  one-cycle pulse; a line start arrived before the fill completed.

## Operation
- Two banks, each LINE_PIXELS×12 registers. `disp_sel` selects the bank on `color_out`. The other bank is the fill bank.
- Edge detect: `nl_d` is the registered `next_line`. `rise = next_line & ~nl_d`.
- FSM states: IDLE, REQ, RECV, DONE.
  - IDLE: wait for `rise`, then go to REQ. No swap and no underrun on this edge.
  - REQ: `req_valid=1`, `req_y` held stable. Go to RECV on `req_valid & req_ready`. `wr_idx` clears to 0.
  - RECV: `pix_ready=1`. Each `pix_valid & pix_ready` writes `pix_data` to fill bank[`wr_idx`] and increments `wr_idx`. The beat at `wr_idx==LINE_PIXELS-1` moves the FSM to DONE.
  - DONE: `line_ready=1`. On `rise`: toggle `disp_sel`, then go to REQ.
- Row to fetch, latched on every `rise` that launches a request: `next_y==V_LINES-1 ? 0 : next_y+1`. The addition is 10-bit, with the wrap compare done before the add.
- `rise` in REQ or RECV:
  - `underrun` pulses high for one cycle.
  - No swap; `disp_sel` and `req_y` are unchanged.
  - The fill continues to completion and reaches DONE.
  - The stale row is shown at the next `rise` after completion.
- `rise` on the same cycle as the final RECV beat: counts as underrun. The beat is written and the FSM enters DONE. The swap waits for the next `rise`.
- Beats arriving outside RECV are not accepted (`pix_ready=0`).

## Timing
- Reset values (async assert, synchronous deassert by the system):
  - FSM=IDLE, `disp_sel=0`, `nl_d=0`, `wr_idx=0`, `req_y=0`.
  - Both banks all 0, so `color_out=0`.
  - `req_valid=0`, `pix_ready=0`, `line_ready=0`, `underrun=0`.
- Reset mid-fill: everything returns to the reset values immediately. Partial bank contents are cleared.
- Swap latency: `rise` is first seen at clock edge k. `disp_sel` toggles at edge k. `color_out` shows the new bank after edge k.
- `req_valid` rises at the edge that detects `rise` and stays high until the handshake cycle inclusive.
- Throughput: one pixel per cycle when `pix_valid` is held. The minimum fill time is 1 request cycle + LINE_PIXELS beats, which fits within an 800-cycle line.
- `underrun` is registered and high for exactly one cycle per offending `rise`.
- `color_out` is a combinational mux of registered banks on `disp_sel`, with no further latency.

## Test plan
- Reset, then the first `next_line` rise with `next_y=0`:
  - No swap and no underrun.
  - `req_valid=1`, `req_y=1` on the next cycle.
  - `color_out` stays all 0.
- Full line: the producer returns x=i → `pix_data=i[11:0]` at one beat per cycle.
  - `line_ready=1` after 480 beats.
  - The next rise toggles `disp_sel`; `color_out[i]=i` at that edge.
  - `req_y` becomes `next_y+1`.
- Wrap: a rise with `next_y=479` in DONE → `req_y=0`.
- Underrun: `pix_valid` stalls after 200 beats and a rise arrives.
  - `underrun` is high for 1 cycle and `disp_sel` is unchanged.
  - Resume the beats → DONE; the swap happens on the following rise.
- Backpressure: `req_ready` is held low for 5 cycles.
  - `req_valid` and `req_y` stay stable.
  - No `pix_ready` until the handshake.
- Async reset asserted mid-RECV at `wr_idx=300`:
  - `req_valid=0`, `pix_ready=0`, `color_out=0` with no clock edge needed.
  - After release, the first rise behaves as the IDLE case.

Source files
------------

// File: rtl/vga_line_feeder.sv
// rtl/vga_line_feeder.sv - double-buffered line source feeding the vga timing block
// One bank is displayed while the other fills from the pixel stream; banks swap on line start.
module vga_line_feeder #(
    parameter int LINE_PIXELS = 480,
    parameter int V_LINES     = 480
) (
    input  logic                      CLK25MHZ,
    input  logic                      ck_rst,
    input  logic                      next_line,
    input  logic [9:0]                next_y,
    output logic                      req_valid,
    output logic [9:0]                req_y,
    input  logic                      req_ready,
    input  logic                      pix_valid,
    input  logic [11:0]               pix_data,
    output logic                      pix_ready,
    output logic [LINE_PIXELS*12-1:0] color_out,
    output logic                      line_ready,
    output logic                      underrun
);

    localparam int IDX_W = $clog2(LINE_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic                               disp_sel_q, disp_sel_d;
    logic                               nl_q, nl_d;
    logic [IDX_W-1:0]                   wr_idx_q, wr_idx_d;
    logic [9:0]                         req_y_q, req_y_d;
    logic                               underrun_q, underrun_d;
    logic [1:0][LINE_PIXELS-1:0][11:0]  bank_q, bank_d;

    logic       rise;
    logic       fill_sel;
    logic [9:0] row_next;

    assign rise     = next_line & ~nl_q;
    assign fill_sel = ~disp_sel_q;
    // Wrap compare on the raw row before the increment.
    assign row_next = (next_y == 10'(V_LINES - 1)) ? 10'd0 : next_y + 10'd1;

    always_comb begin
        state_d    = state_q;
        disp_sel_d = disp_sel_q;
        nl_d       = next_line;
        wr_idx_d   = wr_idx_q;
        req_y_d    = req_y_q;
        underrun_d = 1'b0;
        bank_d     = bank_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    req_y_d = row_next;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wr_idx_d = '0;
                if (rise) underrun_d = 1'b1;
                if (req_ready) state_d = S_RECV;
            end
            S_RECV: begin
                // A late line start is flagged but the fill still runs to completion.
                if (rise) underrun_d = 1'b1;
                if (pix_valid) begin
                    bank_d[fill_sel][wr_idx_q] = pix_data;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == IDX_W'(LINE_PIXELS - 1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rise) begin
                    disp_sel_d = ~disp_sel_q;
                    req_y_d    = row_next;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q    <= S_IDLE;
            disp_sel_q <= 1'b0;
            nl_q       <= 1'b0;
            wr_idx_q   <= '0;
            req_y_q    <= '0;
            underrun_q <= 1'b0;
            bank_q     <= '0;
        end else begin
            state_q    <= state_d;
            disp_sel_q <= disp_sel_d;
            nl_q       <= nl_d;
            wr_idx_q   <= wr_idx_d;
            req_y_q    <= req_y_d;
            underrun_q <= underrun_d;
            bank_q     <= bank_d;
        end
    end

    assign req_valid  = (state_q == S_REQ);
    assign pix_ready  = (state_q == S_RECV);
    assign line_ready = (state_q == S_DONE);
    assign req_y      = req_y_q;
    assign underrun   = underrun_q;
    assign color_out  = bank_q[disp_sel_q];

endmodule

// File: tb/tb_vga_line_feeder.sv
// tb/tb_vga_line_feeder.sv - randomized self-checking bench for vga_line_feeder
// Reference model tracks displayed/fetched rows at line granularity.
module tb_vga_line_feeder;

    localparam int LP = 480;
    localparam int VL = 480;

    logic               CLK25MHZ;
    logic               ck_rst;
    logic               next_line;
    logic [9:0]         next_y;
    logic               req_valid;
    logic [9:0]         req_y;
    logic               req_ready;
    logic               pix_valid;
    logic [11:0]        pix_data;
    logic               pix_ready;
    logic [LP*12-1:0]   color_out;
    logic               line_ready;
    logic               underrun;

    vga_line_feeder #(.LINE_PIXELS(LP), .V_LINES(VL)) dut (
        .CLK25MHZ  (CLK25MHZ),
        .ck_rst    (ck_rst),
        .next_line (next_line),
        .next_y    (next_y),
        .req_valid (req_valid),
        .req_y     (req_y),
        .req_ready (req_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .color_out (color_out),
        .line_ready(line_ready),
        .underrun  (underrun)
    );

    initial CLK25MHZ = 1'b0;
    always #20 CLK25MHZ = ~CLK25MHZ;

    int n_checks = 0;
    int n_pass   = 0;

    int disp [LP];
    int sent [LP];
    bit started;
    bit complete;
    int exp_req_y;
    int fill_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int next_row(input int y);
        return (y == VL - 1) ? 0 : y + 1;
    endfunction

    function automatic int color_mism();
        int m = 0;
        for (int i = 0; i < LP; i++)
            if (color_out[i*12 +: 12] !== 12'(disp[i])) m++;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LP; i++) disp[i] = 0;
        started   = 0;
        complete  = 0;
        exp_req_y = 0;
        fill_pos  = 0;
    endtask

    task automatic model_rise(input int y, output bit u);
        u = 0;
        if (!started) begin
            started   = 1;
            complete  = 0;
            exp_req_y = next_row(y);
        end else if (complete) begin
            for (int i = 0; i < LP; i++) disp[i] = sent[i];
            complete  = 0;
            exp_req_y = next_row(y);
        end else begin
            u = 1;
        end
    endtask

    task automatic rise_and_check(input int y, input string tag);
        bit u;
        model_rise(y, u);
        next_y    = 10'(y);
        next_line = 1'b1;
        @(negedge CLK25MHZ);
        chk({tag, "_underrun"}, 32'(underrun), 32'(u));
        if (!u) chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_req_y"}, 32'(req_y), 32'(exp_req_y));
        chk({tag, "_color_mism"}, 32'(color_mism()), 32'd0);
        @(negedge CLK25MHZ);
        chk({tag, "_underrun_1cyc"}, 32'(underrun), 32'd0);
        repeat ($urandom_range(0, 1)) @(negedge CLK25MHZ);
        next_line = 1'b0;
    endtask

    task automatic do_req(input int bp);
        pix_valid = 1'b1;
        pix_data  = 12'($urandom);
        for (int i = 0; i < bp; i++) begin
            chk("bp_req_valid", 32'(req_valid), 32'd1);
            chk("bp_req_y", 32'(req_y), 32'(exp_req_y));
            chk("bp_pix_ready", 32'(pix_ready), 32'd0);
            @(negedge CLK25MHZ);
        end
        pix_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge CLK25MHZ);
        req_ready = 1'b0;
        chk("hs_req_valid", 32'(req_valid), 32'd0);
        chk("hs_pix_ready", 32'(pix_ready), 32'd1);
        fill_pos = 0;
    endtask

    task automatic fill(input int n, input bit idx_data, input bit stalls,
                        input bit rise_last, input int rise_y, output bit u);
        int budget = 0;
        u = 0;
        while (fill_pos < n && budget < 3000) begin
            @(negedge CLK25MHZ);
            budget++;
            pix_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data  = idx_data ? 12'(fill_pos) : 12'($urandom);
            if (rise_last && fill_pos == LP - 1) begin
                pix_valid = 1'b1;
                next_y    = 10'(rise_y);
                next_line = 1'b1;
                model_rise(rise_y, u);
            end
            if (pix_valid && pix_ready) begin
                sent[fill_pos] = int'(pix_data);
                fill_pos++;
                if (fill_pos == LP) complete = 1;
            end
        end
        if (fill_pos < n) chk("fill_timeout", 32'(fill_pos), 32'(n));
        @(negedge CLK25MHZ);
        pix_valid = 1'b0;
    endtask

    initial begin
        bit u;
        int y;
        ck_rst    = 1'b0;
        next_line = 1'b0;
        next_y    = '0;
        req_ready = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        model_reset();
        repeat (2) @(negedge CLK25MHZ);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_line_ready", 32'(line_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_req_y", 32'(req_y), 32'd0);
        chk("rst_color", 32'(color_mism()), 32'd0);
        ck_rst = 1'b1;
        @(negedge CLK25MHZ);

        rise_and_check(0, "first");
        do_req(5);
        fill(LP, 1'b1, 1'b0, 1'b0, 0, u);
        chk("full_line_ready", 32'(line_ready), 32'd1);

        y = $urandom_range(1, VL - 2);
        rise_and_check(y, "swap_idx");
        do_req($urandom_range(0, 3));
        fill(LP, 1'b0, 1'b1, 1'b0, 0, u);
        chk("rand_line_ready", 32'(line_ready), 32'd1);

        rise_and_check(VL - 1, "wrap");
        do_req(0);

        fill(200, 1'b0, 1'b1, 1'b0, 0, u);
        chk("partial_line_ready", 32'(line_ready), 32'd0);
        rise_and_check($urandom_range(0, VL - 1), "underrun");
        fill(LP, 1'b0, 1'b1, 1'b0, 0, u);
        chk("resume_line_ready", 32'(line_ready), 32'd1);
        rise_and_check($urandom_range(0, VL - 1), "post_underrun");

        do_req(1);
        y = $urandom_range(0, VL - 1);
        fill(LP, 1'b0, 1'b1, 1'b1, y, u);
        chk("coinc_underrun", 32'(underrun), 32'(u));
        chk("coinc_line_ready", 32'(line_ready), 32'd1);
        chk("coinc_color", 32'(color_mism()), 32'd0);
        chk("coinc_req_y", 32'(req_y), 32'(exp_req_y));
        @(negedge CLK25MHZ);
        chk("coinc_underrun_1cyc", 32'(underrun), 32'd0);
        next_line = 1'b0;
        @(negedge CLK25MHZ);
        rise_and_check($urandom_range(0, VL - 1), "coinc_swap");
        do_req(2);

        fill(300, 1'b0, 1'b0, 1'b0, 0, u);
        ck_rst = 1'b0;
        #1;
        model_reset();
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        chk("arst_pix_ready", 32'(pix_ready), 32'd0);
        chk("arst_line_ready", 32'(line_ready), 32'd0);
        chk("arst_color", 32'(color_mism()), 32'd0);
        @(negedge CLK25MHZ);
        ck_rst = 1'b1;
        @(negedge CLK25MHZ);
        rise_and_check($urandom_range(0, VL - 1), "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
